// File: rtl/cpu_prog_loader.sv
// Program loader: takes a length-prefixed, XOR-checksummed image from async pins,
// writes it into instruction memory and releases the CPU once the image verifies.
module cpu_prog_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              load_mode,
    input  logic              byte_strobe,
    input  logic [7:0]        byte_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [2:0] S_SETTLE = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_LEN    = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [8:0]        MAX_LEN  = 9'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]        state_reg, state_next;
    logic [1:0]        settle_cnt_reg;
    logic [2:0]        ld_sync_reg, stb_sync_reg;
    logic [ADDR_W:0]   len_reg, count_reg;
    logic [7:0]        csum_reg, wdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg, cpu_run_reg, busy_reg, err_reg;
    logic [1:0]        err_code_reg;

    logic              stb, ld_rise, ld_level, len_ok, restart;
    logic [ADDR_W:0]   count_inc;

    // Bits [1] are the synchronized levels; bits [2] delay them for edge detection.
    assign stb       = stb_sync_reg[1] & ~stb_sync_reg[2];
    assign ld_rise   = ld_sync_reg[1] & ~ld_sync_reg[2];
    assign ld_level  = ld_sync_reg[1];
    assign len_ok    = (byte_in != 8'd0) && ({1'b0, byte_in} <= MAX_LEN);
    assign count_inc = count_reg + CNT_ONE;
    assign restart   = ena && ld_rise && (state_reg != S_SETTLE) && (state_reg != S_IDLE);

    always_comb begin
        state_next = state_reg;
        if (ena) begin
            case (state_reg)
                S_SETTLE: if (settle_cnt_reg == 2'd3) state_next = S_IDLE;
                S_IDLE:   state_next = ld_level ? S_LEN : S_RUN;
                S_LEN: begin
                    if (ld_rise)  state_next = S_LEN;
                    else if (stb) state_next = len_ok ? S_DATA : S_ERR;
                end
                S_DATA: begin
                    if (ld_rise)                              state_next = S_LEN;
                    else if (stb && (count_inc == len_reg))   state_next = S_CSUM;
                end
                S_CSUM: begin
                    if (ld_rise)  state_next = S_LEN;
                    else if (stb) state_next = (byte_in == csum_reg) ? S_RUN : S_ERR;
                end
                S_RUN, S_ERR: if (ld_rise) state_next = S_LEN;
                default:  state_next = S_SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_SETTLE;
            settle_cnt_reg <= 2'd0;
            ld_sync_reg    <= 3'd0;
            stb_sync_reg   <= 3'd0;
            len_reg        <= '0;
            count_reg      <= '0;
            csum_reg       <= 8'd0;
            wdata_reg      <= 8'd0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= 1'b0;
            cpu_run_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= 2'd0;
        end else begin
            ld_sync_reg  <= {ld_sync_reg[1:0], load_mode};
            stb_sync_reg <= {stb_sync_reg[1:0], byte_strobe};
            // The write pulse is always one cycle; the address advances right after it.
            mem_we_reg <= 1'b0;
            if (mem_we_reg) mem_addr_reg <= mem_addr_reg + ADDR_ONE;
            if (ena) begin
                state_reg   <= state_next;
                busy_reg    <= (state_next == S_LEN) || (state_next == S_DATA) || (state_next == S_CSUM);
                err_reg     <= (state_next == S_ERR);
                cpu_run_reg <= (state_reg == S_RUN) && (state_next == S_RUN);
                if (state_reg == S_SETTLE) settle_cnt_reg <= settle_cnt_reg + 2'd1;
                if (restart) begin
                    count_reg    <= '0;
                    csum_reg     <= 8'd0;
                    err_code_reg <= 2'd0;
                end else if (stb) begin
                    case (state_reg)
                        S_LEN: begin
                            if (len_ok) begin
                                len_reg      <= byte_in[ADDR_W:0];
                                csum_reg     <= 8'd0;
                                count_reg    <= '0;
                                mem_addr_reg <= '0;
                            end else begin
                                err_code_reg <= 2'd1;
                            end
                        end
                        S_DATA: begin
                            mem_we_reg <= 1'b1;
                            wdata_reg  <= byte_in;
                            csum_reg   <= csum_reg ^ byte_in;
                            count_reg  <= count_inc;
                        end
                        S_CSUM: if (byte_in != csum_reg) err_code_reg <= 2'd2;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_run   = cpu_run_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: boot, good/bad images, restart, collision, ena hold, reset.
module tb_cpu_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       load_mode = 1'b0;
    logic       byte_strobe = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run, busy, err;
    logic [1:0] err_code;
    logic [4:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int we_long = 0;
    logic we_prev = 1'b0;
    logic [3:0] wa_q[$];
    logic [7:0] wd_q[$];

    cpu_prog_loader #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .load_mode(load_mode),
        .byte_strobe(byte_strobe), .byte_in(byte_in),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    // Write log, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            if (we_prev) we_long++;
        end
        we_prev = mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
        if (idx < wa_q.size()) begin
            chk({tag, "_addr"}, 32'(wa_q[idx]), 32'(a));
            chk({tag, "_data"}, 32'(wd_q[idx]), 32'(d));
        end else begin
            chk({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in = b;
        byte_strobe = 1'b1;
        repeat (3) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic toggle_load();
        @(negedge clk);
        load_mode = 1'b0;
        repeat (4) @(negedge clk);
        load_mode = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Cold boot: cpu_run rises on the 6th edge after release
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("boot_run_edge5", 32'(cpu_run), 32'd0);
        @(posedge clk);
        #1 chk("boot_run_edge6", 32'(cpu_run), 32'd1);
        repeat (4) @(negedge clk);
        chk("boot_no_writes", 32'(wa_q.size()), 32'd0);
        chk("boot_busy", 32'(busy), 32'd0);

        // Good load
        @(negedge clk);
        load_mode = 1'b1;
        repeat (4) @(negedge clk);
        chk("good_busy", 32'(busy), 32'd1);
        chk("good_run_dropped", 32'(cpu_run), 32'd0);
        clear_log();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h44);
        chk("good_count", 32'(count), 32'd3);
        send_byte(8'h77);
        chk("good_nwr", 32'(wa_q.size()), 32'd3);
        chk_wr("good_wr0", 0, 4'd0, 8'h11);
        chk_wr("good_wr1", 1, 4'd1, 8'h22);
        chk_wr("good_wr2", 2, 4'd2, 8'h44);
        chk("good_run", 32'(cpu_run), 32'd1);
        chk("good_err", 32'(err), 32'd0);
        chk("good_busy_done", 32'(busy), 32'd0);

        // Bad checksum
        toggle_load();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h44);
        send_byte(8'h76);
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_code", 32'(err_code), 32'd2);
        chk("badcs_run", 32'(cpu_run), 32'd0);
        toggle_load();
        chk("reload_busy", 32'(busy), 32'd1);
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_code", 32'(err_code), 32'd0);

        // Bad length 0x00
        clear_log();
        send_byte(8'h00);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_code", 32'(err_code), 32'd1);
        chk("len0_nwr", 32'(wa_q.size()), 32'd0);

        // Bad length 0x11
        toggle_load();
        send_byte(8'h11);
        chk("len17_code", 32'(err_code), 32'd1);
        chk("len17_busy", 32'(busy), 32'd0);

        // Full-depth image: data 0x00,0x11..0xFF, checksum 0x00
        toggle_load();
        clear_log();
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] n;
            n = 4'(i);
            send_byte({n, n});
        end
        chk("len16_nwr", 32'(wa_q.size()), 32'd16);
        chk("len16_count", 32'(count), 32'd16);
        chk("len16_addr_wrap", 32'(mem_addr), 32'd0);
        chk_wr("len16_wr0", 0, 4'd0, 8'h00);
        chk_wr("len16_wr9", 9, 4'd9, 8'h99);
        chk_wr("len16_wr15", 15, 4'd15, 8'hFF);
        send_byte(8'h00);
        chk("len16_run", 32'(cpu_run), 32'd1);

        // Restart after two data bytes
        toggle_load();
        clear_log();
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("restart_pre_count", 32'(count), 32'd2);
        toggle_load();
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("restart_nwr", 32'(wa_q.size()), 32'd4);
        chk_wr("restart_wr2", 2, 4'd0, 8'h01);
        chk_wr("restart_wr3", 3, 4'd1, 8'h02);
        chk("restart_run", 32'(cpu_run), 32'd1);

        // ld_rise coincident with stb
        toggle_load();
        clear_log();
        send_byte(8'h03);
        send_byte(8'hAA);
        @(negedge clk);
        load_mode = 1'b0;
        repeat (4) @(negedge clk);
        byte_in = 8'h55;
        byte_strobe = 1'b1;
        load_mode = 1'b1;
        repeat (3) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("collide_nwr", 32'(wa_q.size()), 32'd1);
        chk("collide_count", 32'(count), 32'd0);
        chk("collide_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5A);
        chk_wr("collide_wr1", 1, 4'd0, 8'h5A);
        chk("collide_run", 32'(cpu_run), 32'd1);

        // ena=0 during DATA
        toggle_load();
        clear_log();
        send_byte(8'h03);
        send_byte(8'h10);
        @(negedge clk);
        ena = 1'b0;
        send_byte(8'h20);
        chk("ena_count_hold", 32'(count), 32'd1);
        chk("ena_nwr", 32'(wa_q.size()), 32'd1);
        chk("ena_addr_hold", 32'(mem_addr), 32'd1);
        @(negedge clk);
        ena = 1'b1;
        send_byte(8'h30);
        chk_wr("ena_wr1", 1, 4'd1, 8'h30);
        chk("ena_count", 32'(count), 32'd2);
        send_byte(8'h40);
        send_byte(8'h60);
        chk("ena_run", 32'(cpu_run), 32'd1);
        chk("ena_err", 32'(err), 32'd0);

        // Reset mid-load, load_mode still high
        toggle_load();
        send_byte(8'h02);
        send_byte(8'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_relen_busy", 32'(busy), 32'd1);
        chk("midrst_run", 32'(cpu_run), 32'd0);

        chk("we_single_cycle", 32'(we_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_prog_loader.md
# cpu_prog_loader

Program loader for the simple CPU, placed between the chip's dedicated input pins and the core's instruction memory. It accepts a length-prefixed, XOR-checksummed program one byte at a time from a pin-level strobe and writes each byte into instruction memory. It holds the core halted until the image verifies, then releases it. An error is latched and the core stays halted if the image is malformed.

## Interface
- `ADDR_W`, 4: instruction memory address width; depth is 2^ADDR_W bytes.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. One clock; all state resets on the rising `clk` edge where `rst`=1.
- `ena` in 1: when 0, the FSM, counters and outputs hold, and strobe edges are discarded. Synchronizer flops keep running.
- `load_mode` in 1: asynchronous pin. 1 requests a program load.
- `byte_strobe` in 1: asynchronous pin. A rising edge marks `byte_in` valid.
- `byte_in` in 8: data byte. Must be stable from the strobe rise until 4 `clk` cycles after it.
- `mem_we` out 1: instruction-memory write enable, one-cycle pulse.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 8: write data.
- `cpu_run` out 1: 1 releases the CPU core from halt.
- `busy` out 1: 1 while in LEN, DATA or CSUM.
- `err` out 1: sticky error flag.
- `err_code` out 2: 0 none, 1 bad length, 2 checksum mismatch.
- `count` out ADDR_W+1: number of data bytes written in the current load.

## Operation
- Synchronization:
  - `load_mode` and `byte_strobe` each pass through a 2-flop synchronizer.
  - A third flop on the strobe path gives a one-cycle rising-edge pulse `stb`.
  - A third flop on the load path gives the rising-edge pulse `ld_rise`.
- FSM states:
  - SETTLE (reset state): a 2-bit counter runs 4 cycles so the synchronizers fill, then goes to IDLE.
  - IDLE: synced `load_mode`=1 goes to LEN; otherwise goes to RUN. IDLE lasts exactly one cycle.
  - LEN: on `stb`, `L` = `byte_in`.
    - 1 ≤ L ≤ 2^ADDR_W: store L, clear the checksum and `count`, set `mem_addr`=0, go to DATA.
    - Otherwise go to ERR with `err_code`=1.
  - DATA: on `stb`, for each byte:
    - pulse `mem_we` with `mem_wdata`=`byte_in` at the current `mem_addr`;
    - csum ^= `byte_in`;
    - `count`++; `mem_addr`++ after the write (wraps to 0 after the last location; unused once L bytes are written).
    - When `count` reaches L, go to CSUM.
  - CSUM: on `stb`, if `byte_in` == csum go to RUN; otherwise go to ERR with `err_code`=2. No memory write occurs.
  - RUN: `cpu_run`=1. `ld_rise` goes to LEN and drops `cpu_run` on the same transition edge.
  - ERR: `err`=1, `cpu_run`=0. Only `ld_rise` exits, to LEN; entering LEN clears `err` and `err_code`.
- `ld_rise` in LEN, DATA or CSUM restarts the load: go to LEN and clear `count` and the checksum. Already-written memory is not erased.
- `load_mode` falling in LEN, DATA or CSUM has no effect; the load completes normally.
- `stb` in SETTLE, IDLE, RUN or ERR is ignored.
- If `stb` and `ld_rise` occur in the same cycle, `ld_rise` wins and that byte is discarded.
- `rst` mid-load: everything returns to reset values and the FSM goes to SETTLE. `cpu_run`=0 until the FSM reaches RUN again.

## Timing
- All outputs are registered.
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `cpu_run`=0, `busy`=0;
  - `err`=0, `err_code`=0, `count`=0.
- Strobe latency: if edge E0 first samples `byte_strobe`=1, `stb` is high between E1 and E2. `mem_we`, `mem_wdata`, `count` and the state update at E2. `mem_we` falls at E3.
- Pin `load_mode` to `ld_rise` has the same 2-edge latency.
- From reset release with `load_mode`=0: SETTLE for 4 cycles, IDLE for 1 cycle, `cpu_run`=1 at the 6th rising edge after the first edge with `rst`=0.
- Maximum byte rate: one strobe rise per 4 cycles. `byte_strobe` high and low times must each be ≥ 2 cycles.
- `busy` is high exactly while in LEN, DATA or CSUM.

## Test plan
- Cold boot: reset, `load_mode`=0 → `cpu_run`=1 on the 6th edge after reset release; `mem_we` never pulses.
- Good load:
  - `load_mode`=1; send bytes 0x03, 0x11, 0x22, 0x44, then 0x77 (checksum).
  - Required: writes (0,0x11), (1,0x22), (2,0x44), one-cycle `mem_we` pulse each; `count`=3; `cpu_run`=1; `err`=0.
- Bad checksum: same image with checksum 0x76 → `err`=1, `err_code`=2, `cpu_run`=0. Then toggling `load_mode` low/high gives `busy`=1 and `err`=0.
- Bad length:
  - Length 0x00 → `err_code`=1, no writes.
  - Length 0x11 with ADDR_W=4 → `err_code`=1.
  - Length 0x10 → 16 writes; `mem_addr` wraps to 0 after address 15.
- Restart and collision: `ld_rise` after 2 data bytes → `count`=0 and the next byte is treated as a length. `ld_rise` coincident with `stb` → no `mem_we` in that cycle.
- `ena`=0 during DATA: strobes are ignored and `count` holds. After `ena` returns to 1, the next strobe writes at the held `mem_addr`.
